key_encoder_83: RTL

//  8-to-3 key encoder, the input-side counterpart of the board's 3-8 LED decoder.
//  - Samples eight active-low push-buttons and synchronizes them.
//  - Priority-encodes them; the highest index wins.
//  - Debounces the encoded key.
//  - Reports a stable 3-bit code with level-valid and one-cycle press/release pulses.

---
 rtl/key_encoder_83_pkg.sv | 29 ++
 rtl/key_encoder_83_prio_enc.sv | 35 +++
 rtl/key_encoder_83.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/key_encoder_83_pkg.sv
// -----------------------------------------------------------------------------
// key_encoder_83_pkg
// Shared definitions for the 8-to-3 key encoder (and its 3-8 LED decoder
// counterpart): FSM state encoding, the enable pattern that gates the block,
// the idle level of the active-low key bus, and a small enable helper.
// -----------------------------------------------------------------------------
package key_encoder_83_pkg;

  // Debounce FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_DEBOUNCE = 2'b01,
    ST_PRESSED  = 2'b10,
    ST_RELEASE  = 2'b11
  } state_t;

  // The block only runs when enable carries exactly this pattern; the LED
  // decoder uses the same gating so both can share one enable bus.
  localparam logic [2:0] ENABLE_PATTERN = 3'b100;

  // Active-low keys: all ones means nothing pressed.
  localparam logic [7:0] KEYS_IDLE = 8'hFF;

  // True when the enable bus selects this block.
  function automatic logic is_enabled(input logic [2:0] enable);
    return (enable == ENABLE_PATTERN);
  endfunction

endpackage

// File: rtl/key_encoder_83_prio_enc.sv
// -----------------------------------------------------------------------------
// prio_enc_83
// Combinational 8->3 priority encoder for active-low inputs. The highest
// index holding a 0 wins.
// Ports:
//   i_key_n  in  8  active-low request lines (0 = asserted)
//   o_code   out 3  index of highest asserted line, 0 when none
//   o_any    out 1  at least one line asserted
// -----------------------------------------------------------------------------
module prio_enc_83 (
  input  logic [7:0] i_key_n,
  output logic [2:0] o_code,
  output logic       o_any
);

  // Highest-index-first priority match; '?' bits are masked by a higher key.
  always_comb begin
    o_code = 3'd0;
    casez (i_key_n)
      8'b0???????: o_code = 3'd7;
      8'b10??????: o_code = 3'd6;
      8'b110?????: o_code = 3'd5;
      8'b1110????: o_code = 3'd4;
      8'b11110???: o_code = 3'd3;
      8'b111110??: o_code = 3'd2;
      8'b1111110?: o_code = 3'd1;
      8'b11111110: o_code = 3'd0;
      default:     o_code = 3'd0;
    endcase
  end

  // Any zero on the bus means some key is down.
  assign o_any = ~&i_key_n;

endmodule

// File: rtl/key_encoder_83.sv
// -----------------------------------------------------------------------------
// key_encoder_83
// 8-to-3 key encoder: synchronizes eight active-low push-buttons, priority
// encodes them (highest index wins), debounces the encoded key and reports a
// stable code with a level valid and one-cycle press/release pulses. The code
// output can drive the 3-8 LED decoder's switch input directly.
// Parameters:
//   DEB_CYCLES  consecutive stable cycles needed to accept a press or release
//               (>= 2)
// Ports:
//   i_clk      in  1  system clock, all logic on posedge
//   i_rst_n    in  1  synchronous active-low reset
//   i_enable   in  3  block runs only when equal to ENABLE_PATTERN
//   i_key_n    in  8  raw asynchronous keys, 0 = pressed
//   o_code     out 3  accepted key index, held when not valid
//   o_valid    out 1  high while an accepted key is held
//   o_press    out 1  one-cycle pulse on press acceptance
//   o_release  out 1  one-cycle pulse on release acceptance
// -----------------------------------------------------------------------------
module key_encoder_83
  import key_encoder_83_pkg::*;
#(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_enable,
  input  logic [7:0] i_key_n,
  output logic [2:0] o_code,
  output logic       o_valid,
  output logic       o_press,
  output logic       o_release
);

  localparam int            CW      = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [7:0]    r_sync1;
  logic [7:0]    r_sync2;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_cand;
  logic [2:0]    r_code;
  logic          r_valid;
  logic          r_press;
  logic          r_release;

  logic [2:0]    w_pcode;
  logic          w_any;
  logic          w_en;

  // Two-flop synchronizer; resets to the all-released level so no phantom
  // press is seen while the chain refills after reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= KEYS_IDLE;
      r_sync2 <= KEYS_IDLE;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  prio_enc_83 u_prio_enc (
    .i_key_n (r_sync2),
    .o_code  (w_pcode),
    .o_any   (w_any)
  );

  assign w_en = is_enabled(i_enable);

  // Debounce FSM with counter and registered outputs. The counter is cleared
  // on every entry to a counting state and only increments below CNT_MAX, so
  // it can never wrap.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_cand    <= 3'd0;
      r_code    <= 3'd0;
      r_valid   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_en && w_any) begin
            r_state <= ST_DEBOUNCE;
            r_cand  <= w_pcode;
            r_cnt   <= '0;
          end
        end

        ST_DEBOUNCE: begin
          // Any change of the winning key restarts from IDLE.
          if (!w_en || !w_any || (w_pcode != r_cand)) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= ST_PRESSED;
            r_cnt   <= '0;
            r_code  <= r_cand;
            r_valid <= 1'b1;
            r_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        ST_PRESSED: begin
          // Losing enable abandons the key silently. A different winning key
          // (higher-priority key joining, or a switch) is treated as a release
          // of the held key first.
          if (!w_en) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end else if (!w_any || (w_pcode != r_code)) begin
            r_state <= ST_RELEASE;
            r_cnt   <= '0;
          end
        end

        ST_RELEASE: begin
          if (!w_en) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
          end else if (w_any && (w_pcode == r_code)) begin
            // Held key came back: bounce absorbed, valid never dropped.
            r_state <= ST_PRESSED;
          end else if (r_cnt == CNT_MAX) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_code    = r_code;
  assign o_valid   = r_valid;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule
